// File: rtl/processor_pkg.sv
// Shared definitions for the multi-cycle processor: FSM states, ALU
// operation codes, instruction opcodes, field positions and special
// register indices.
package processor_pkg;

  typedef enum logic [1:0] {
    FETCH,
    EXEC,
    MEM
  } state_e;

  // Encoded to match the low three bits of the R-type aluop field.
  typedef enum logic [2:0] {
    ALU_ADD = 3'd0,
    ALU_SUB = 3'd1,
    ALU_AND = 3'd2,
    ALU_OR  = 3'd3,
    ALU_SLL = 3'd4,
    ALU_SRA = 3'd5
  } alu_op_e;

  localparam logic [4:0] OP_RTYPE = 5'b00000;
  localparam logic [4:0] OP_J     = 5'b00001;
  localparam logic [4:0] OP_BNE   = 5'b00010;
  localparam logic [4:0] OP_JAL   = 5'b00011;
  localparam logic [4:0] OP_JR    = 5'b00100;
  localparam logic [4:0] OP_ADDI  = 5'b00101;
  localparam logic [4:0] OP_BLT   = 5'b00110;
  localparam logic [4:0] OP_SW    = 5'b00111;
  localparam logic [4:0] OP_LW    = 5'b01000;
  localparam logic [4:0] OP_SETX  = 5'b10101;
  localparam logic [4:0] OP_BEX   = 5'b10110;

  localparam logic [4:0] ALUOP_MAX = 5'd5;

  localparam int unsigned OPCODE_LSB = 27;
  localparam int unsigned RD_LSB     = 22;
  localparam int unsigned RS_LSB     = 17;
  localparam int unsigned RT_LSB     = 12;
  localparam int unsigned SHAMT_LSB  = 7;
  localparam int unsigned ALUOP_LSB  = 2;
  localparam int unsigned IMM_W      = 17;
  localparam int unsigned TARGET_W   = 27;

  localparam logic [4:0] REG_ZERO   = 5'd0;
  localparam logic [4:0] REG_STATUS = 5'd30;
  localparam logic [4:0] REG_LINK   = 5'd31;

  // Status codes written to r30 on signed overflow.
  localparam logic [31:0] OVF_ADD  = 32'd1;
  localparam logic [31:0] OVF_ADDI = 32'd2;
  localparam logic [31:0] OVF_SUB  = 32'd3;

  function automatic logic [31:0] sext_imm(input logic [IMM_W-1:0] imm);
    return {{(32 - IMM_W){imm[IMM_W-1]}}, imm};
  endfunction

endpackage

// File: rtl/processor_alu.sv
// Combinational ALU.
//   a, b      : operands
//   op        : operation (add/sub/and/or/sll/sra)
//   shamt     : shift amount for sll/sra (shifts apply to a)
//   result    : operation result, wraps on overflow
//   overflow  : signed overflow for add/sub, 0 otherwise
//   ne        : a != b
//   lt        : signed a < b
module processor_alu
  import processor_pkg::*;
(
  input  logic [31:0] a,
  input  logic [31:0] b,
  input  alu_op_e     op,
  input  logic [4:0]  shamt,
  output logic [31:0] result,
  output logic        overflow,
  output logic        ne,
  output logic        lt
);

  logic [31:0] sum;
  logic [31:0] diff;

  assign sum  = a + b;
  assign diff = a - b;
  assign ne   = (a != b);
  assign lt   = ($signed(a) < $signed(b));

  always_comb begin
    result   = '0;
    overflow = 1'b0;
    case (op)
      ALU_ADD: begin
        result   = sum;
        overflow = (a[31] == b[31]) && (sum[31] != a[31]);
      end
      ALU_SUB: begin
        result   = diff;
        overflow = (a[31] != b[31]) && (diff[31] != a[31]);
      end
      ALU_AND: result = a & b;
      ALU_OR:  result = a | b;
      ALU_SLL: result = a << shamt;
      ALU_SRA: result = $unsigned($signed(a) >>> shamt);
      default: result = '0;
    endcase
  end

endmodule

// File: rtl/processor.sv
// Multi-cycle processor: FETCH -> EXEC -> (MEM for lw) -> FETCH.
//   clock, reset          : rising-edge clock, async active-low reset
//   address_imem, q_imem  : synchronous instruction ROM interface
//   ctrl_*, data_writeReg : register file control / write data
//   data_readRegA/B       : combinational register file read data
//   wren, address_dmem,
//   data, q_dmem          : synchronous data RAM interface
// The PC is held for the whole instruction so q_imem stays valid in EXEC
// and MEM; decode therefore works directly off q_imem and all strobes are
// qualified by the current state.
module processor
  import processor_pkg::*;
#(
  parameter logic [31:0] RESET_PC = '0
) (
  input  logic        clock,
  input  logic        reset,
  output logic [31:0] address_imem,
  input  logic [31:0] q_imem,
  output logic        ctrl_writeEnable,
  output logic [4:0]  ctrl_writeReg,
  output logic [4:0]  ctrl_readRegA,
  output logic [4:0]  ctrl_readRegB,
  output logic [31:0] data_writeReg,
  input  logic [31:0] data_readRegA,
  input  logic [31:0] data_readRegB,
  output logic        wren,
  output logic [31:0] address_dmem,
  output logic [31:0] data,
  input  logic [31:0] q_dmem
);

  state_e      state;
  logic [31:0] pc;

  logic [4:0]  opcode, rd, rs, rt, shamt, aluop;
  logic [31:0] imm, target, pc_plus1;
  logic [1:0]  unused_bits;

  logic [4:0]  read_a, read_b, wr_idx;
  logic [31:0] alu_a, alu_b, alu_result, wr_data, next_pc;
  alu_op_e     alu_op;
  logic        alu_ovf, alu_ne, alu_lt;
  logic        wr_en, mem_wr, is_lw;

  assign opcode      = q_imem[OPCODE_LSB +: 5];
  assign rd          = q_imem[RD_LSB +: 5];
  assign rs          = q_imem[RS_LSB +: 5];
  assign rt          = q_imem[RT_LSB +: 5];
  assign shamt       = q_imem[SHAMT_LSB +: 5];
  assign aluop       = q_imem[ALUOP_LSB +: 5];
  assign imm         = sext_imm(q_imem[IMM_W-1:0]);
  assign target      = {{(32 - TARGET_W){1'b0}}, q_imem[TARGET_W-1:0]};
  assign unused_bits = q_imem[1:0];
  assign pc_plus1    = pc + 32'd1;

  processor_alu u_alu (
    .a        (alu_a),
    .b        (alu_b),
    .op       (alu_op),
    .shamt    (shamt),
    .result   (alu_result),
    .overflow (alu_ovf),
    .ne       (alu_ne),
    .lt       (alu_lt)
  );

  always_comb begin
    read_a  = rs;
    read_b  = rt;
    alu_a   = data_readRegA;
    alu_b   = data_readRegB;
    alu_op  = ALU_ADD;
    wr_en   = 1'b0;
    wr_idx  = rd;
    wr_data = alu_result;
    mem_wr  = 1'b0;
    is_lw   = 1'b0;
    next_pc = pc_plus1;
    case (opcode)
      OP_RTYPE: begin
        if (aluop <= ALUOP_MAX) begin
          alu_op = alu_op_e'(aluop[2:0]);
          wr_en  = 1'b1;
          if (alu_ovf && (alu_op == ALU_ADD || alu_op == ALU_SUB)) begin
            wr_idx  = REG_STATUS;
            wr_data = (alu_op == ALU_ADD) ? OVF_ADD : OVF_SUB;
          end
        end
      end
      OP_ADDI: begin
        alu_b = imm;
        wr_en = 1'b1;
        if (alu_ovf) begin
          wr_idx  = REG_STATUS;
          wr_data = OVF_ADDI;
        end
      end
      OP_LW: begin
        alu_b   = imm;
        is_lw   = 1'b1;
        wr_en   = 1'b1;
        wr_data = q_dmem;
      end
      OP_SW: begin
        read_b = rd;
        alu_b  = imm;
        mem_wr = 1'b1;
      end
      OP_J: next_pc = target;
      OP_JAL: begin
        wr_en   = 1'b1;
        wr_idx  = REG_LINK;
        wr_data = pc_plus1;
        next_pc = target;
      end
      OP_JR: begin
        read_b  = rd;
        next_pc = data_readRegB;
      end
      // Branches compare rd (port B) against rs (port A); operands are
      // swapped into the ALU so its a<b flag reads as rd<rs.
      OP_BNE: begin
        read_b = rd;
        alu_a  = data_readRegB;
        alu_b  = data_readRegA;
        if (alu_ne) next_pc = pc_plus1 + imm;
      end
      OP_BLT: begin
        read_b = rd;
        alu_a  = data_readRegB;
        alu_b  = data_readRegA;
        if (alu_lt) next_pc = pc_plus1 + imm;
      end
      OP_SETX: begin
        wr_en   = 1'b1;
        wr_idx  = REG_STATUS;
        wr_data = target;
      end
      OP_BEX: begin
        read_a = REG_STATUS;
        if (data_readRegA != '0) next_pc = target;
      end
      default: ;
    endcase
  end

  assign address_imem     = pc;
  assign ctrl_readRegA    = read_a;
  assign ctrl_readRegB    = read_b;
  assign ctrl_writeReg    = wr_idx;
  assign data_writeReg    = wr_data;
  assign ctrl_writeEnable = wr_en && (wr_idx != REG_ZERO) &&
                            ((state == EXEC && !is_lw) || (state == MEM && is_lw));
  assign wren             = mem_wr && (state == EXEC);
  assign address_dmem     = alu_result;
  assign data             = data_readRegB;

  always_ff @(posedge clock or negedge reset) begin
    if (!reset) begin
      state <= FETCH;
      pc    <= RESET_PC;
    end else begin
      case (state)
        FETCH: state <= EXEC;
        EXEC: begin
          if (is_lw) begin
            state <= MEM;
          end else begin
            state <= FETCH;
            pc    <= next_pc;
          end
        end
        MEM: begin
          state <= FETCH;
          pc    <= next_pc;
        end
        default: state <= FETCH;
      endcase
    end
  end

endmodule

// File: tb/tb_processor.sv
// Self-checking bench for processor: table of single-instruction vectors
// plus short multi-instruction programs and a mid-lw reset sequence.
module tb_processor;

  localparam logic [4:0] O_R = 5'b00000, O_J = 5'b00001, O_BNE = 5'b00010,
                         O_JAL = 5'b00011, O_JR = 5'b00100, O_ADDI = 5'b00101,
                         O_BLT = 5'b00110, O_SW = 5'b00111, O_LW = 5'b01000,
                         O_SETX = 5'b10101, O_BEX = 5'b10110;

  logic        clock = 1'b0;
  logic        reset = 1'b0;
  logic [31:0] address_imem, q_imem = '0;
  logic        ctrl_writeEnable;
  logic [4:0]  ctrl_writeReg, ctrl_readRegA, ctrl_readRegB;
  logic [31:0] data_writeReg, data_readRegA, data_readRegB;
  logic        wren;
  logic [31:0] address_dmem, data, q_dmem = '0;

  int tests = 0;
  int fails = 0;

  always #5 clock = ~clock;

  processor #(.RESET_PC(32'd0)) dut (
    .clock(clock), .reset(reset),
    .address_imem(address_imem), .q_imem(q_imem),
    .ctrl_writeEnable(ctrl_writeEnable), .ctrl_writeReg(ctrl_writeReg),
    .ctrl_readRegA(ctrl_readRegA), .ctrl_readRegB(ctrl_readRegB),
    .data_writeReg(data_writeReg),
    .data_readRegA(data_readRegA), .data_readRegB(data_readRegB),
    .wren(wren), .address_dmem(address_dmem), .data(data), .q_dmem(q_dmem)
  );

  // Environment: regfile, instruction ROM, data RAM.
  logic [31:0] rom [4096];
  logic [31:0] regs [32];
  logic [31:0] ram [4096];
  logic [31:0] init_regs [32];
  logic [31:0] init_ram [4096];
  logic        load = 1'b0;
  int          wr_count = 0;

  assign data_readRegA = (ctrl_readRegA == 5'd0) ? '0 : regs[ctrl_readRegA];
  assign data_readRegB = (ctrl_readRegB == 5'd0) ? '0 : regs[ctrl_readRegB];

  always @(posedge clock) begin
    q_imem <= rom[address_imem[11:0]];
    q_dmem <= ram[address_dmem[11:0]];
    if (load) begin
      regs     <= init_regs;
      ram      <= init_ram;
      wr_count <= 0;
    end else begin
      if (ctrl_writeEnable) begin
        wr_count <= wr_count + 1;
        if (ctrl_writeReg != 5'd0) regs[ctrl_writeReg] <= data_writeReg;
      end
      if (wren) ram[address_dmem[11:0]] <= data;
      if (ctrl_writeEnable && wren) begin
        fails = fails + 1;
        $display("FAIL both_strobes: got we=1 wren=1 required not both");
      end
    end
  end

  function automatic logic [31:0] enc_r(input logic [4:0] rd, rs, rt, sh, op);
    return {O_R, rd, rs, rt, sh, op, 2'b00};
  endfunction
  function automatic logic [31:0] enc_i(input logic [4:0] op, rd, rs, input logic [16:0] imm);
    return {op, rd, rs, imm};
  endfunction
  function automatic logic [31:0] enc_j(input logic [4:0] op, input logic [26:0] t);
    return {op, t};
  endfunction

  task automatic check(input logic [127:0] name, input logic [31:0] act, input logic [31:0] exp);
    tests = tests + 1;
    if (act !== exp) begin
      fails = fails + 1;
      $display("FAIL %0s: got %h required %h", name, act, exp);
    end
  endtask

  // Clears ROM and preload images; caller fills them before start().
  task automatic clear_env();
    for (int i = 0; i < 4096; i++) begin
      rom[i]      = '0;
      init_ram[i] = 32'hA500_0000 | i;
    end
    for (int i = 0; i < 32; i++) init_regs[i] = '0;
  endtask

  task automatic start();
    reset = 1'b0;
    load  = 1'b1;
    @(posedge clock); #1;
    load  = 1'b0;
    @(negedge clock);
    reset = 1'b1;
  endtask

  task automatic run_until(input logic [31:0] tgt, input int max, output int cyc);
    cyc = 0;
    while (address_imem !== tgt && cyc < max) begin
      @(posedge clock); #1;
      cyc++;
    end
  endtask

  typedef struct {
    logic [127:0] name;
    logic [31:0]  instr;
    logic [4:0]   ia;
    logic [31:0]  va;
    logic [4:0]   ib;
    logic [31:0]  vb;
    bit           chk_mem;
    logic [31:0]  chk_idx;
    logic [31:0]  exp_val;
    logic [31:0]  exp_pc;
    int           exp_cyc;
    int           exp_wr;
  } vec_t;

  function automatic vec_t mk(input logic [127:0] n, input logic [31:0] ins,
                              input logic [4:0] ia, input logic [31:0] va,
                              input logic [4:0] ib, input logic [31:0] vb,
                              input bit cm, input logic [31:0] ci, input logic [31:0] ev,
                              input logic [31:0] ep, input int ec, input int ew);
    vec_t v;
    v.name = n; v.instr = ins; v.ia = ia; v.va = va; v.ib = ib; v.vb = vb;
    v.chk_mem = cm; v.chk_idx = ci; v.exp_val = ev; v.exp_pc = ep;
    v.exp_cyc = ec; v.exp_wr = ew;
    return v;
  endfunction

  vec_t vecs[$];
  int   cyc;
  logic [31:0] act;

  initial begin
    vecs.push_back(mk("add",      enc_r(3,1,2,0,0), 1, 5, 2, 7, 0, 3, 32'd12, 1, 2, 1));
    vecs.push_back(mk("sub",      enc_r(3,1,2,0,1), 1, 5, 2, 7, 0, 3, 32'hFFFF_FFFE, 1, 2, 1));
    vecs.push_back(mk("and",      enc_r(3,1,2,0,2), 1, 32'hF0F0, 2, 32'hFF00, 0, 3, 32'hF000, 1, 2, 1));
    vecs.push_back(mk("or",       enc_r(3,1,2,0,3), 1, 32'hF0F0, 2, 32'hFF00, 0, 3, 32'hFFF0, 1, 2, 1));
    vecs.push_back(mk("sll",      enc_r(3,1,0,4,4), 1, 32'h8000_0001, 0, 0, 0, 3, 32'h0000_0010, 1, 2, 1));
    vecs.push_back(mk("sra",      enc_r(3,1,0,4,5), 1, 32'h8000_0000, 0, 0, 0, 3, 32'hF800_0000, 1, 2, 1));
    vecs.push_back(mk("addi_neg", enc_i(O_ADDI,3,1,17'h1FFFD), 1, 10, 0, 0, 0, 3, 32'd7, 1, 2, 1));
    vecs.push_back(mk("add_ovf",  enc_r(3,1,2,0,0), 1, 32'h7FFF_FFFF, 2, 1, 0, 30, 32'd1, 1, 2, 1));
    vecs.push_back(mk("sub_ovf",  enc_r(3,1,2,0,1), 1, 32'h8000_0000, 2, 1, 0, 30, 32'd3, 1, 2, 1));
    vecs.push_back(mk("addi_ovf", enc_i(O_ADDI,3,1,17'd1), 1, 32'h7FFF_FFFF, 0, 0, 0, 30, 32'd2, 1, 2, 1));
    vecs.push_back(mk("add_r0",   enc_r(0,1,2,0,0), 1, 5, 2, 7, 0, 0, 32'd0, 1, 2, 0));
    vecs.push_back(mk("mul_nop",  enc_r(3,1,2,0,6), 1, 5, 2, 7, 0, 3, 32'd0, 1, 2, 0));
    vecs.push_back(mk("bad_op",   {5'b11111, 5'd3, 5'd1, 17'd1}, 1, 5, 0, 0, 0, 3, 32'd0, 1, 2, 0));
    vecs.push_back(mk("j",        enc_j(O_J, 27'd10), 0, 0, 0, 0, 0, 31, 32'd0, 10, 2, 0));
    vecs.push_back(mk("jal",      enc_j(O_JAL, 27'd10), 0, 0, 0, 0, 0, 31, 32'd1, 10, 2, 1));
    vecs.push_back(mk("jr",       enc_i(O_JR,5,0,0), 5, 32'h40, 0, 0, 0, 5, 32'h40, 32'h40, 2, 0));
    vecs.push_back(mk("bne_tk",   enc_i(O_BNE,1,2,17'd2), 1, 1, 2, 2, 0, 1, 32'd1, 3, 2, 0));
    vecs.push_back(mk("bne_eq",   enc_i(O_BNE,1,2,17'd2), 1, 9, 2, 9, 0, 1, 32'd9, 1, 2, 0));
    vecs.push_back(mk("blt_tk",   enc_i(O_BLT,1,2,17'd5), 1, 32'hFFFF_FFFF, 2, 0, 0, 1, 32'hFFFF_FFFF, 6, 2, 0));
    vecs.push_back(mk("blt_nt",   enc_i(O_BLT,1,2,17'd5), 1, 0, 2, 32'hFFFF_FFFF, 0, 1, 32'd0, 1, 2, 0));
    vecs.push_back(mk("blt_eq",   enc_i(O_BLT,1,2,17'd5), 1, 4, 2, 4, 0, 1, 32'd4, 1, 2, 0));
    vecs.push_back(mk("setx",     enc_j(O_SETX, 27'd5), 0, 0, 0, 0, 0, 30, 32'd5, 1, 2, 1));
    vecs.push_back(mk("bex_tk",   enc_j(O_BEX, 27'd20), 30, 7, 0, 0, 0, 30, 32'd7, 20, 2, 0));
    vecs.push_back(mk("bex_nt",   enc_j(O_BEX, 27'd20), 30, 0, 0, 0, 0, 30, 32'd0, 1, 2, 0));
    vecs.push_back(mk("lw",       enc_i(O_LW,4,1,17'd4), 1, 8, 0, 0, 0, 4, 32'hA500_000C, 1, 3, 1));
    vecs.push_back(mk("sw",       enc_i(O_SW,1,2,17'd4), 1, 100, 2, 0, 1, 4, 32'd100, 1, 2, 0));

    // Reset state
    clear_env();
    repeat (3) @(posedge clock);
    #1;
    check("rst_pc", address_imem, 32'd0);
    check("rst_we", {31'd0, ctrl_writeEnable}, 32'd0);
    check("rst_wren", {31'd0, wren}, 32'd0);

    foreach (vecs[k]) begin
      clear_env();
      rom[0] = vecs[k].instr;
      init_regs[vecs[k].ia] = vecs[k].va;
      init_regs[vecs[k].ib] = vecs[k].vb;
      start();
      run_until(vecs[k].exp_pc, 8, cyc);
      check({vecs[k].name, "_cyc"}, cyc, vecs[k].exp_cyc);
      check({vecs[k].name, "_pc"}, address_imem, vecs[k].exp_pc);
      act = vecs[k].chk_mem ? ram[vecs[k].chk_idx[11:0]] : regs[vecs[k].chk_idx[4:0]];
      check({vecs[k].name, "_val"}, act, vecs[k].exp_val);
      check({vecs[k].name, "_wr"}, wr_count, vecs[k].exp_wr);
    end

    // addi/addi/add program
    clear_env();
    rom[0] = enc_i(O_ADDI,1,0,17'd5);
    rom[1] = enc_i(O_ADDI,2,0,17'd7);
    rom[2] = enc_r(3,1,2,0,0);
    rom[3] = enc_j(O_J, 27'd3);
    start();
    run_until(3, 20, cyc);
    check("prog_add_cyc", cyc, 6);
    check("prog_add_r3", regs[3], 32'd12);

    // sw then lw through RAM
    clear_env();
    rom[0] = enc_i(O_ADDI,1,0,17'd100);
    rom[1] = enc_i(O_SW,1,0,17'd4);
    rom[2] = enc_i(O_LW,4,0,17'd4);
    rom[3] = enc_j(O_J, 27'd3);
    start();
    run_until(3, 20, cyc);
    check("prog_mem_cyc", cyc, 7);
    check("prog_mem_ram4", ram[4], 32'd100);
    check("prog_mem_r4", regs[4], 32'd100);

    // Overflow leaves rd untouched
    clear_env();
    rom[0] = enc_r(2,1,1,0,0);
    rom[1] = enc_j(O_J, 27'd1);
    init_regs[1] = 32'h7FFF_FFFF;
    init_regs[2] = 32'h55;
    start();
    run_until(1, 10, cyc);
    check("ovf_r30", regs[30], 32'd1);
    check("ovf_r2", regs[2], 32'h55);

    // bne skips two instructions
    clear_env();
    rom[0] = enc_i(O_BNE,1,2,17'd2);
    rom[1] = enc_i(O_ADDI,5,0,17'd1);
    rom[2] = enc_i(O_ADDI,6,0,17'd1);
    rom[3] = enc_i(O_ADDI,7,0,17'd9);
    rom[4] = enc_j(O_J, 27'd4);
    init_regs[1] = 1;
    init_regs[2] = 2;
    start();
    run_until(4, 20, cyc);
    check("skip_cyc", cyc, 4);
    check("skip_r5", regs[5], 32'd0);
    check("skip_r6", regs[6], 32'd0);
    check("skip_r7", regs[7], 32'd9);

    // jal / jr / setx / bex
    clear_env();
    rom[0]  = enc_j(O_JAL, 27'd10);
    rom[10] = enc_i(O_ADDI,8,0,17'd3);
    rom[11] = enc_i(O_JR,31,0,17'd0);
    rom[1]  = enc_j(O_SETX, 27'd5);
    rom[2]  = enc_j(O_BEX, 27'd20);
    rom[20] = enc_j(O_J, 27'd20);
    start();
    run_until(20, 30, cyc);
    check("call_cyc", cyc, 10);
    check("call_r31", regs[31], 32'd1);
    check("call_r8", regs[8], 32'd3);
    check("call_r30", regs[30], 32'd5);

    // Reset during lw MEM state
    clear_env();
    rom[0] = enc_i(O_ADDI,9,0,17'd1);
    rom[1] = enc_i(O_LW,4,0,17'd4);
    init_regs[4] = 32'h77;
    start();
    run_until(1, 10, cyc);
    @(posedge clock); #1;
    @(posedge clock); #1;
    check("mid_we_mem", {31'd0, ctrl_writeEnable}, 32'd1);
    reset = 1'b0;
    #1;
    check("mid_pc", address_imem, 32'd0);
    check("mid_we", {31'd0, ctrl_writeEnable}, 32'd0);
    @(posedge clock); #1;
    check("mid_r4_kept", regs[4], 32'h77);
    check("mid_wr", wr_count, 1);
    @(negedge clock);
    reset = 1'b1;
    run_until(2, 20, cyc);
    check("restart_cyc", cyc, 5);
    check("restart_r4", regs[4], 32'hA500_0004);

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule

// File: doc/processor.md
PROCESSOR -- requirements
Module: processor

Interface
REQ-001 Parameter RESET_PC, default 0: PC value loaded by reset.
REQ-002 clock  in  1  single clock; all state updates on rising edge.
REQ-003 reset  in  1  asynchronous, active-low reset.
REQ-004 address_imem  out  32  instruction address, equal to PC; ROM uses bits [11:0].
REQ-005 q_imem  in  32  instruction word; synchronous ROM, valid one rising edge after address is presented.
REQ-006 ctrl_writeEnable  out  1  regfile write strobe, sampled on rising edge.
REQ-007 ctrl_writeReg  out  5  regfile write index.
REQ-008 ctrl_readRegA / ctrl_readRegB  out  5 each  regfile read indices.
REQ-009 data_writeReg  out  32  regfile write data.
REQ-010 data_readRegA / data_readRegB  in  32 each  combinational regfile read data.
REQ-011 wren  out  1  RAM write strobe, sampled on rising edge.
REQ-012 address_dmem  out  32  data address; RAM uses bits [11:0].
REQ-013 data  out  32  RAM write data.
REQ-014 q_dmem  in  32  RAM read data, valid one rising edge after address.

Function
REQ-015 Multi-cycle FSM, states FETCH -> EXEC -> (MEM for lw only) -> FETCH; PC held constant for the whole instruction so q_imem stays valid.
REQ-016 Timing: ALU/branch/jump/sw = 2 cycles (FETCH, EXEC); lw = 3 cycles; PC, regfile write and RAM write all occur on the rising edge ending the last state.
REQ-017 Fields: opcode[31:27], rd[26:22], rs[21:17], rt[16:12], shamt[11:7], aluop[6:2], imm[16:0] sign-extended to 32, target[26:0] zero-extended.
REQ-018 opcode 00000, aluop 00000 add, 00001 sub, 00010 and, 00011 or, 00100 sll by shamt, 00101 sra by shamt; rd <= result.
REQ-019 00101 addi rd=rs+imm; 01000 lw rd=MEM[rs+imm]; 00111 sw MEM[rs+imm]=rd.
REQ-020 00001 j PC=T; 00011 jal r31=PC+1, PC=T; 00100 jr PC=rd.
REQ-021 00010 bne: if rd!=rs PC=PC+1+imm; 00110 blt: if signed rd<rs PC=PC+1+imm; else PC=PC+1.
REQ-022 10101 setx r30=T; 10110 bex: if r30!=0 PC=T else PC+1.
REQ-023 Read port usage: A=rs (A=r30 for bex), B=rt for R-type, B=rd for sw/bne/blt/jr.
REQ-024 Signed overflow on add/addi/sub writes r30 with 1/2/3 respectively instead of rd.
REQ-025 All other opcodes/aluops (incl. mul 00110, div 00111) execute as NOP: PC=PC+1, no writes.
REQ-026 Writes with destination r0 suppressed (ctrl_writeEnable=0); reads of r0 rely on regfile returning 0.
REQ-027 Arithmetic 32-bit two's complement, wraps silently except per REQ-024; PC wraps 0xFFFFFFFF->0.
REQ-028 ctrl_writeEnable and wren asserted only in the final state of the relevant instruction, never both together.

Reset
REQ-029 reset low asynchronously forces PC=RESET_PC, state=FETCH, ctrl_writeEnable=0, wren=0; other outputs don't-care while low.
REQ-030 Reset mid-instruction abandons it with no register or memory write; first FETCH follows the first rising edge after release.

Structure
REQ-031 Shared package holds opcode and aluop constants, field bit positions, FSM state encoding, r30/r31 indices.
REQ-032 One sub-module natural: alu (add/sub/and/or/sll/sra, overflow, not-equal, less-than flags).

Verification
REQ-033 addi r1,r0,5; addi r2,r0,7; add r3,r1,r2 -> r3=12, each instruction 2 cycles.
REQ-034 addi r1,r0,100; sw r1,4(r0); lw r4,4(r0) -> RAM[4]=100, r4=100, lw takes 3 cycles.
REQ-035 r1=0x7FFFFFFF, add r2,r1,r1 -> r30=1, r2 unchanged; sub overflow -> r30=3.
REQ-036 bne r1,r2,2 with r1!=r2 skips two instructions; blt with rd=-1, rs=0 taken; equal operands fall through.
REQ-037 jal 10 -> r31=PC+1, PC=10; jr r31 returns; setx 5 then bex 20 -> PC=20.
REQ-038 Pulse reset low during a lw's MEM state -> no write to rd, PC=0, execution restarts cleanly.
